// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the fetch PC, steps sequentially or to a branch target,
// handshakes with instruction memory and remembers a branch taken while the PC is blocked.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                BLT,
    input  logic                BGE,
    input  logic signed [63:0]  Imm,
    input  logic                stall,
    input  logic                fetch_ready,
    output logic [63:0]         PC_Out,
    output logic                fetch_valid,
    output logic                redirect,
    output logic [CNT_W-1:0]    fetch_cnt,
    output logic                br_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic        pend_vld;
    logic [63:0] pend_tgt;
    logic        taken;
    logic        advance;
    logic [63:0] target;
    logic [63:0] seq_pc;
    logic [63:0] next_pc;

    // Offsets are signed; the sum wraps modulo 2^64 with no overflow reporting.
    function automatic logic [63:0] wrap_add(input logic [63:0] base,
                                             input logic signed [63:0] ofs);
        return base + $unsigned(ofs);
    endfunction

    always_comb begin
        taken   = BLT | BGE;
        target  = wrap_add(PC_Out, Imm);
        seq_pc  = wrap_add(PC_Out, 64'(PC_STEP));
        advance = (state == FETCH) && fetch_valid && fetch_ready && !stall;
        next_pc = pend_vld ? pend_tgt : (taken ? target : seq_pc);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            PC_Out      <= RESET_PC;
            fetch_valid <= 1'b0;
            redirect    <= 1'b0;
            fetch_cnt   <= '0;
            br_err      <= 1'b0;
            pend_vld    <= 1'b0;
        end else begin
            if (BLT && BGE)
                br_err <= 1'b1;

            redirect <= 1'b0;
            if (advance) begin
                PC_Out    <= next_pc;
                redirect  <= pend_vld | taken;
                fetch_cnt <= fetch_cnt + CNT_W'(1);
                pend_vld  <= 1'b0;
            end else if (taken && !pend_vld) begin
                // First taken branch while blocked wins; later ones are dropped.
                pend_vld <= 1'b1;
                pend_tgt <= target;
            end

            case (state)
                IDLE: begin
                    state       <= FETCH;
                    fetch_valid <= 1'b1;
                end
                FETCH: begin
                    if (stall) begin
                        state       <= HOLD;
                        fetch_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state       <= FETCH;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the PC rules.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        BLT = 1'b0;
    logic        BGE = 1'b0;
    logic [63:0] Imm = 64'h0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [63:0] PC_Out;
    logic        fetch_valid;
    logic        redirect;
    logic [31:0] fetch_cnt;
    logic        br_err;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_redir;
    logic [31:0] m_cnt;
    logic        m_err;
    logic [63:0] m_pend_q[$];
    int          m_mode;    // 0 idle after reset, 1 fetching, 2 holding

    pc_sequencer #(.RESET_PC(RST_PC), .PC_STEP(4), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .BLT(BLT), .BGE(BGE), .Imm(Imm),
        .stall(stall), .fetch_ready(fetch_ready), .PC_Out(PC_Out),
        .fetch_valid(fetch_valid), .redirect(redirect), .fetch_cnt(fetch_cnt),
        .br_err(br_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [63:0] tgt;
        bit tk, adv;
        if (!reset_n) begin
            m_pc = RST_PC; m_valid = 0; m_redir = 0; m_cnt = 0; m_err = 0;
            m_pend_q.delete(); m_mode = 0;
            return;
        end
        tk  = BLT || BGE;
        tgt = m_pc + Imm;
        if (BLT && BGE) m_err = 1;
        adv = (m_mode == 1) && fetch_ready && !stall;
        m_redir = 0;
        if (adv) begin
            if (m_pend_q.size() > 0) begin m_pc = m_pend_q.pop_front(); m_redir = 1; end
            else if (tk)             begin m_pc = tgt; m_redir = 1; end
            else                     m_pc = m_pc + 64'd4;
            m_cnt = m_cnt + 1;
        end else if (tk && m_pend_q.size() == 0) begin
            m_pend_q.push_back(tgt);
        end
        if (m_mode == 0)               m_mode = 1;
        else if (m_mode == 1 && stall) m_mode = 2;
        else if (m_mode == 2 && !stall) m_mode = 1;
        m_valid = (m_mode == 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic blt, input logic bge, input logic [63:0] imm,
                         input logic stl, input logic rdy);
        BLT = blt; BGE = bge; Imm = imm; stall = stl; fetch_ready = rdy;
    endtask

    task automatic test_reset();
        reset_n = 0;
        drive(0, 0, 64'h0, 0, 0);
        tick(); tick();
        n_vec++; if (PC_Out !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h exp %h", PC_Out, RST_PC); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
        n_vec++; if (fetch_cnt !== 32'd0 || br_err !== 1'b0 || redirect !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl got cnt=%0d err=%b redir=%b exp 0/0/0", fetch_cnt, br_err, redirect);
        end
        reset_n = 1;
        tick();
        n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL release_valid got %b exp 1", fetch_valid); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        drive(0, 0, 64'h0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = RST_PC + 64'(4 * i);
            n_vec++; if (PC_Out !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d] got %h exp %h", i, PC_Out, exp_pc); end
        end
        n_vec++; if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL seq_cnt got %0d exp 3", fetch_cnt); end
    endtask

    task automatic test_taken();
        drive(1, 0, 64'h200 - 64'h10C, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'h200) begin n_err++; $display("FAIL jump_200 got %h exp 200", PC_Out); end
        drive(1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'h1F0) begin n_err++; $display("FAIL taken_pc got %h exp 1f0", PC_Out); end
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL taken_redirect got %b exp 1", redirect); end
        drive(0, 0, 64'h0, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'h1F4 || redirect !== 1'b0) begin
            n_err++; $display("FAIL redirect_drop got pc=%h redir=%b exp 1f4/0", PC_Out, redirect);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] c0;
        drive(0, 1, 64'h300 - 64'h1F4, 0, 1);
        tick();
        c0 = fetch_cnt;
        drive(0, 1, 64'h40, 0, 0);
        tick(); tick();
        n_vec++; if (PC_Out !== 64'h300 || fetch_cnt !== c0) begin
            n_err++; $display("FAIL bp_hold got pc=%h cnt=%0d exp 300/%0d", PC_Out, fetch_cnt, c0);
        end
        drive(0, 0, 64'h0, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'h340) begin n_err++; $display("FAIL bp_pending got %h exp 340", PC_Out); end
        n_vec++; if (fetch_cnt !== c0 + 32'd1) begin n_err++; $display("FAIL bp_cnt got %0d exp %0d", fetch_cnt, c0 + 1); end
    endtask

    task automatic test_stall_pending();
        drive(1, 0, 64'hC0, 0, 1);
        tick();
        drive(1, 0, 64'h8, 1, 1);
        tick();
        n_vec++; if (fetch_valid !== 1'b0 || PC_Out !== 64'h400) begin
            n_err++; $display("FAIL stall_hold got valid=%b pc=%h exp 0/400", fetch_valid, PC_Out);
        end
        drive(0, 0, 64'h0, 0, 1);
        tick();
        n_vec++; if (fetch_valid !== 1'b1 || PC_Out !== 64'h400) begin
            n_err++; $display("FAIL stall_resume got valid=%b pc=%h exp 1/400", fetch_valid, PC_Out);
        end
        tick();
        n_vec++; if (PC_Out !== 64'h408 || redirect !== 1'b1) begin
            n_err++; $display("FAIL stall_pending got pc=%h redir=%b exp 408/1", PC_Out, redirect);
        end
    endtask

    task automatic test_wrap_error();
        drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFC - 64'h408, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got %h exp fffffffffffffffc", PC_Out); end
        drive(0, 0, 64'h0, 0, 1);
        tick();
        n_vec++; if (PC_Out !== 64'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 0", PC_Out); end
        n_vec++; if (br_err !== 1'b0) begin n_err++; $display("FAIL err_early got %b exp 0", br_err); end
        drive(1, 1, 64'h10, 0, 1);
        tick();
        n_vec++; if (br_err !== 1'b1 || PC_Out !== 64'h10) begin
            n_err++; $display("FAIL err_set got err=%b pc=%h exp 1/10", br_err, PC_Out);
        end
        drive(0, 0, 64'h0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (br_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", br_err); end
    endtask

    task automatic test_reset_override();
        drive(1, 0, 64'h80, 1, 0);
        tick();
        reset_n = 0;
        tick();
        n_vec++; if (PC_Out !== RST_PC || br_err !== 1'b0 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_override got pc=%h err=%b valid=%b exp 100/0/0", PC_Out, br_err, fetch_valid);
        end
        reset_n = 1;
        drive(0, 0, 64'h0, 0, 1);
        tick(); tick();
        n_vec++; if (PC_Out !== RST_PC + 64'd4 || redirect !== 1'b0) begin
            n_err++; $display("FAIL rst_pend_clear got pc=%h redir=%b exp 104/0", PC_Out, redirect);
        end
    endtask

    task automatic test_random();
        reset_n = 0;
        drive(0, 0, 64'h0, 0, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            BLT = ($urandom_range(0, 3) == 0);
            BGE = ($urandom_range(0, 4) == 0);
            Imm = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                              : 64'($signed(32'($urandom_range(0, 255)) - 32'd128));
            stall = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_vec++; if (PC_Out !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, PC_Out, m_pc); end
            n_vec++; if (fetch_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, fetch_valid, m_valid); end
            n_vec++; if (redirect !== m_redir) begin n_err++; $display("FAIL rnd_redirect[%0d] got %b exp %b", i, redirect, m_redir); end
            n_vec++; if (fetch_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, fetch_cnt, m_cnt); end
            n_vec++; if (br_err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b exp %b", i, br_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_taken();
        test_backpressure();
        test_stall_pending();
        test_wrap_error();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
